// File: rtl/uart_mem_dump.sv
// Memory readback serializer for the UART program loader.
// Reads one DATA_WIDTH word per READ/LOAD pair and emits its bytes
// MSB byte first through a tx_start/tx_done handshake.
module uart_mem_dump #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0]       LAST_IDX = IW'(NB - 1);
  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                cur, nxt;
  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         byte_idx;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  last_byte, last_word;

  assign last_byte = (byte_idx == LAST_IDX);
  assign last_word = (remaining == ONE_WORD);
  assign state     = cur;
  // Byte 0 is the top byte of the word; the word register only changes in
  // LOAD, so this stays stable through SEND and WAIT.
  assign tx_data   = word_q[DATA_WIDTH - 1 - int'(byte_idx) * BYTE_WIDTH -: BYTE_WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: if (start) nxt = (num_words == '0) ? DONE : READ;
      READ: nxt = LOAD;
      LOAD: nxt = SEND;
      SEND: nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (!last_byte)     nxt = SEND;
          else if (last_word) nxt = DONE;
          else                nxt = READ;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs, decoded from the next state so
  // each one lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      word_q    <= '0;
      byte_idx  <= '0;
      remaining <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_start <= (nxt == SEND);
      busy     <= (nxt != IDLE);
      done     <= (nxt == DONE);
      case (cur)
        IDLE: begin
          if (start && num_words != '0) begin
            rd_addr   <= start_addr;
            remaining <= num_words;
          end
        end
        LOAD: begin
          word_q   <= rd_data;
          byte_idx <= '0;
        end
        WAIT: begin
          if (tx_done) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + 1'b1;
            end else if (!last_word) begin
              remaining <= remaining - 1'b1;
              rd_addr   <= rd_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
